// File: rtl/mult_arbiter_pkg.sv
// Shared widths and types for the round-robin multiplier arbiter.
package mult_arbiter_pkg;
    localparam int OPW   = 24;
    localparam int PRODW = 48;

    typedef logic [OPW-1:0]   op_t;
    typedef logic [PRODW-1:0] prod_t;
endpackage

// File: rtl/mult_arbiter_mult.sv
// Full-width unsigned multiplier shared by all requesters; purely combinational.
module Int_Multiplier
    import mult_arbiter_pkg::*;
(
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] p
);
    assign p = PRODW'(a) * PRODW'(b);
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding one shared 24x24 multiplier through a 2-stage
// pipeline (S1 operands, S2 product) with backpressure from resp_ready.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [PRODW-1:0]    resp_product,
    output logic                busy
);
    logic           s1_vld_q, s1_vld_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    op_t            s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic           s2_vld_q, s2_vld_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;
    prod_t          s2_prod_q, s2_prod_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           s2_free, s1_ld, gnt_any, accept;
    logic [IDW-1:0] gnt_id;
    prod_t          mul_p;
    int             idx;

    Int_Multiplier u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mul_p)
    );

    always_comb begin
        s2_free = !s2_vld_q || resp_ready;
        s1_ld   = !s1_vld_q || s2_free;

        // First valid requester at or above the pointer, wrapping mod NREQ.
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end

        req_ready = '0;
        if (gnt_any && s1_ld && !rst) req_ready[gnt_id] = 1'b1;
        accept = |req_ready;

        ptr_d = ptr_q;
        if (accept) ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;

        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (s1_ld) begin
            s1_vld_d = accept;
            if (accept) begin
                s1_id_d = gnt_id;
                s1_a_d  = req_a[gnt_id*OPW +: OPW];
                s1_b_d  = req_b[gnt_id*OPW +: OPW];
            end
        end

        s2_vld_d  = s2_vld_q;
        s2_id_d   = s2_id_q;
        s2_prod_d = s2_prod_q;
        if (s2_free) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_id_d   = s1_id_q;
                s2_prod_d = mul_p;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_id_q   <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_id_q   <= '0;
            s2_prod_q <= '0;
            ptr_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s2_vld_q  <= s2_vld_d;
            s2_id_q   <= s2_id_d;
            s2_prod_q <= s2_prod_d;
            ptr_q     <= ptr_d;
        end
    end

    assign resp_valid   = s2_vld_q;
    assign resp_id      = s2_id_q;
    assign resp_product = s2_prod_q;
    assign busy         = s1_vld_q | s2_vld_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter against a queue-based transaction model.
module tb_mult_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*24-1:0]  req_a, req_b;
    logic                resp_valid, resp_ready, busy;
    logic [IDW-1:0]      resp_id;
    logic [47:0]         resp_product;

    mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_product(resp_product), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [47:0] prod; int acc; } ent_t;
    ent_t q[$];
    int   mptr, edge_n, nchk, nerr, g_id;

    logic [NREQ-1:0] o_rdy, e_rdy;
    logic            o_rv, e_rv, o_busy, e_busy;
    logic [IDW-1:0]  o_id;
    logic [47:0]     o_prod;
    int              e_id;
    logic [47:0]     e_prod;

    function automatic logic [23:0] opnd(int i, logic [NREQ*24-1:0] v);
        return v[i*24 +: 24];
    endfunction

    // One clock: sample DUT vs. model before the edge, then advance the model.
    task automatic tick();
        int j;
        #1;
        o_rdy = req_ready; o_rv = resp_valid; o_id = resp_id;
        o_prod = resp_product; o_busy = busy;
        e_rdy = '0;
        if (q.size() < 2 || resp_ready)
            for (int k = 0; k < NREQ; k++) begin
                j = (mptr + k) % NREQ;
                if (e_rdy == 0 && req_valid[j]) e_rdy[j] = 1'b1;
            end
        e_busy = (q.size() > 0);
        e_rv   = (q.size() > 0) && (q[0].acc < edge_n);
        e_id   = (q.size() > 0) ? q[0].id : 0;
        e_prod = (q.size() > 0) ? q[0].prod : '0;
        @(posedge clk);
        edge_n++;
        g_id = -1;
        if (e_rv && resp_ready) void'(q.pop_front());
        for (int k = 0; k < NREQ; k++)
            if (e_rdy[k]) begin
                g_id = k;
                q.push_back('{k, 48'(opnd(k, req_a)) * 48'(opnd(k, req_b)), edge_n});
                mptr = (k + 1) % NREQ;
            end
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0; resp_ready = 1'b1;
        for (int n = 0; n < 8 && q.size() > 0; n++) tick();
        nchk++;
        if (q.size() != 0) begin
            nerr++; $display("FAIL drain: %0d entries left, want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; resp_ready = 1'b1; req_a = '1; req_b = '1;
        repeat (2) @(negedge clk);
        nchk++;
        if ({resp_valid, busy, resp_id, resp_product, req_ready} !== '0) begin
            nerr++;
            $display("FAIL reset_state: rv=%b busy=%b id=%0d prod=%h rdy=%b, want all 0",
                     resp_valid, busy, resp_id, resp_product, req_ready);
        end
        rst = 1'b0; req_valid = '0;
        q.delete(); mptr = 0;
        @(negedge clk);
    endtask

    task automatic test_rr_order();
        req_valid = '1; resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_a = {$urandom, $urandom, $urandom}; req_b = {$urandom, $urandom, $urandom};
            tick();
            nchk++;
            if (g_id !== c % NREQ) begin
                nerr++; $display("FAIL rr_order: cycle %0d grant %0d, want %0d", c, g_id, c % NREQ);
            end
            if (c >= 2) begin
                nchk++;
                if (o_rv !== 1'b1 || o_id !== IDW'(e_id) || o_prod !== e_prod) begin
                    nerr++;
                    $display("FAIL rr_stream: cycle %0d rv=%b id=%0d prod=%h, want 1 %0d %h",
                             c, o_rv, o_id, o_prod, e_id, e_prod);
                end
            end
        end
        drain();
    endtask

    task automatic test_single();
        req_valid = 4'b0100; resp_ready = 1'b1;
        req_a[2*24 +: 24] = 24'd3; req_b[2*24 +: 24] = 24'd5;
        tick();
        nchk++;
        if (o_rdy !== 4'b0100) begin
            nerr++; $display("FAIL single_ready: got %b, want 0100", o_rdy);
        end
        req_valid = '0;
        tick();
        nchk++;
        if (o_rv !== 1'b0 || o_busy !== 1'b1) begin
            nerr++; $display("FAIL single_lat1: rv=%b busy=%b, want 0 1", o_rv, o_busy);
        end
        tick();
        nchk++;
        if (o_rv !== 1'b1 || o_id !== 2'd2 || o_prod !== 48'd15) begin
            nerr++; $display("FAIL single_resp: rv=%b id=%0d prod=%0d, want 1 2 15", o_rv, o_id, o_prod);
        end
        drain();
    endtask

    task automatic test_corners();
        logic [47:0] got[$];
        resp_ready = 1'b1;
        req_a[0 +: 24] = 24'hFFFFFF; req_b[0 +: 24] = 24'hFFFFFF;
        req_a[24 +: 24] = 24'h0;     req_b[24 +: 24] = 24'hABCDEF;
        req_valid = 4'b0001; tick();
        req_valid = 4'b0010; tick();
        req_valid = '0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (o_rv) got.push_back(o_prod);
        end
        nchk++;
        if (got.size() != 2 || got[0] !== 48'hFFFFFE000001 || got[1] !== 48'h0) begin
            nerr++;
            $display("FAIL corners: %0d resps first=%h second=%h, want 2 fffffe000001 0",
                     got.size(), (got.size() > 0) ? got[0] : 48'hx, (got.size() > 1) ? got[1] : 48'hx);
        end
        drain();
    endtask

    task automatic test_stall();
        int acc = 0;
        logic [47:0] held = '0;
        logic [IDW-1:0] held_id = '0;
        req_valid = '1; resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_a = {$urandom, $urandom, $urandom}; req_b = {$urandom, $urandom, $urandom};
            tick();
            if (o_rdy != 0) acc++;
            if (c == 2) begin held = o_prod; held_id = o_id; end
            if (c > 2) begin
                nchk++;
                if (o_rdy !== '0 || o_rv !== 1'b1 || o_prod !== held || o_id !== held_id) begin
                    nerr++;
                    $display("FAIL stall_hold: c=%0d rdy=%b rv=%b id=%0d prod=%h, want 0 1 %0d %h",
                             c, o_rdy, o_rv, o_id, o_prod, held_id, held);
                end
            end
        end
        nchk++;
        if (acc != 2) begin
            nerr++; $display("FAIL stall_accepts: got %0d, want 2", acc);
        end
        req_valid = '0; resp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            nchk++;
            if (o_rv !== 1'b1 || o_id !== IDW'(e_id) || o_prod !== e_prod) begin
                nerr++;
                $display("FAIL stall_release: c=%0d rv=%b id=%0d prod=%h, want 1 %0d %h",
                         c, o_rv, o_id, o_prod, e_id, e_prod);
            end
        end
        drain();
    endtask

    task automatic test_drop();
        int id1 = 0;
        resp_ready = 1'b0; req_valid = 4'b1101;
        repeat (3) tick();
        req_valid = 4'b1111;
        repeat (2) begin
            tick();
            nchk++;
            if (o_rdy !== '0) begin
                nerr++; $display("FAIL drop_stalled: rdy=%b, want 0000", o_rdy);
            end
        end
        req_valid = '0; resp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (o_rv && o_id == 2'd1) id1++;
        end
        nchk++;
        if (id1 != 0) begin
            nerr++; $display("FAIL drop_id1: %0d responses for id 1, want 0", id1);
        end
        drain();
    endtask

    task automatic test_random();
        logic [23:0] c3[3];
        c3[0] = 24'h0; c3[1] = 24'hFFFFFF; c3[2] = 24'h1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || g_id == i) begin
                    req_a[i*24 +: 24] = ($urandom_range(0, 7) == 0) ? c3[$urandom_range(0, 2)] : 24'($urandom);
                    req_b[i*24 +: 24] = ($urandom_range(0, 7) == 0) ? c3[$urandom_range(0, 2)] : 24'($urandom);
                end
                req_valid[i] = ($urandom_range(0, 9) < 6);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
            nchk++;
            if (o_rdy !== e_rdy || o_rv !== e_rv || o_busy !== e_busy) begin
                nerr++;
                $display("FAIL rand_ctl: c=%0d rdy=%b rv=%b busy=%b, want %b %b %b",
                         c, o_rdy, o_rv, o_busy, e_rdy, e_rv, e_busy);
            end
            if (e_rv) begin
                nchk++;
                if (o_id !== IDW'(e_id) || o_prod !== e_prod) begin
                    nerr++;
                    $display("FAIL rand_data: c=%0d id=%0d prod=%h, want %0d %h", c, o_id, o_prod, e_id, e_prod);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        req_valid = '1; resp_ready = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        nchk++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            nerr++;
            $display("FAIL reset_mid: rv=%b busy=%b rdy=%b, want 0 0 0", resp_valid, busy, req_ready);
        end
        @(negedge clk);
        rst = 1'b0; q.delete(); mptr = 0;
        resp_ready = 1'b1;
        tick();
        nchk++;
        if (o_rdy !== 4'b0001 || o_rv !== 1'b0) begin
            nerr++; $display("FAIL reset_ptr: rdy=%b rv=%b, want 0001 0", o_rdy, o_rv);
        end
        req_valid = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            nchk++;
            if (o_rv !== e_rv || (e_rv && o_id !== IDW'(e_id))) begin
                nerr++; $display("FAIL reset_flush: rv=%b id=%0d, want %b %0d", o_rv, o_id, e_rv, e_id);
            end
        end
        drain();
    endtask

    initial begin
        nchk = 0; nerr = 0; edge_n = 0; mptr = 0; g_id = -1;
        req_valid = '0; resp_ready = 1'b1; req_a = '0; req_b = '0; rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr_order();
        test_single();
        test_corners();
        test_stall();
        test_drop();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
